dft_mac_engine: RTL and testbench
=================================

Name: dft_mac_engine

Overview:
Parametrised direct-DFT compute core: X[k] = sum over n of x[n]*W^(k*n), for runtime length N ≤ 2^LOG2N_MAX, complex samples.
- Reads samples from an external sample RAM port and twiddles from an external twiddle ROM port, both 1-cycle read latency.
- Multiply-accumulates bin by bin and streams each finished bin out over a valid/ready handshake.
- Replaces the fixed-width n/k counter, MAC and accumulator datapath under the FFT top; the FSM-side start/done control sits inside this block.

Parameters:
DATA_W, 16, sample real/imag width, signed two's complement
TW_W, 16, twiddle component width, signed Q1.(TW_W-1)
LOG2N_MAX, 12, log2 of max transform length; address width
ACC_W, DATA_W+LOG2N_MAX+1, accumulator/result component width

Ports:
clk  in  1  clock, all logic rising-edge
n_Reset  in  1  asynchronous active-low reset
i_start  in  1  start pulse, sampled only in IDLE
i_points  in  LOG2N_MAX+1  N, latched at start; legal 2..2^LOG2N_MAX
o_busy  out  1  high from accepted start until done
o_done  out  1  1-cycle pulse after the last bin is accepted
o_err  out  1  1-cycle pulse on start with illegal i_points
o_smp_rd  out  1  sample read strobe
o_smp_addr  out  LOG2N_MAX  sample index n
i_smp_re, i_smp_im  in  DATA_W each  sample data, valid 1 cycle after o_smp_rd
o_tw_addr  out  LOG2N_MAX  twiddle index (k*n) mod N
i_tw_cos, i_tw_sin  in  TW_W each  cos and -sin of 2*pi*idx/N, valid 1 cycle after o_smp_rd
o_res_valid  out  1  result valid
i_res_ready  in  1  result accept
o_res_k  out  LOG2N_MAX  bin index
o_res_re, o_res_im  out  ACC_W each  bin value

Behaviour:
- Reset (async, any time, including mid-run):
  - FSM goes to IDLE; all counters, accumulators, pipeline valids and the output register clear.
  - All outputs are 0.
  - No partial result is emitted afterwards.
- FSM states: IDLE, RUN, DRAIN, WAIT_OUT, FIN.
- IDLE:
  - i_start with 2 ≤ i_points ≤ 2^LOG2N_MAX: latch N; set k=0, n=0, idx=0; go to RUN.
  - i_start with illegal i_points: pulse o_err, stay in IDLE.
  - i_start is ignored in every other state.
- RUN:
  - Each cycle: o_smp_rd=1, o_smp_addr=n, o_tw_addr=idx.
  - Then n++ and idx = idx+k, wrapping with idx ≥ N ? idx-N. Twiddle index is generated incrementally; no multiplier.
  - After n=N-1 is issued, go to DRAIN.
- Pipeline:
  - Stage 1 (cycle after issue): complex multiply, re = a*c - b*s, im = a*s + b*c, at full width DATA_W+TW_W+1.
  - Round half-up by adding 2^(TW_W-2), arithmetic-shift right by TW_W-1, register the result.
  - Stage 2: accumulate into ACC_W accumulators. The first sample of a bin loads instead of adding.
  - Issue-to-accumulate latency is 3 cycles.
- DRAIN:
  - Wait 3 cycles for the last accumulate.
  - If the output register is empty, or being accepted this cycle, transfer {k, acc} into it and set o_res_valid. Otherwise go to WAIT_OUT and hold acc.
  - After the transfer: if k=N-1 go to FIN; else k++, n=0, idx=0, go to RUN.
- WAIT_OUT: performs the same transfer as soon as the output frees.
- Output handshake:
  - o_res_* remain stable while o_res_valid && !i_res_ready.
  - Valid drops on acceptance unless a new transfer happens in the same cycle.
  - Bin k+1 computation overlaps the wait on bin k.
- FIN: when the output is empty, pulse o_done, drop o_busy, return to IDLE.
- Overflow: the accumulator cannot overflow for |x| ≤ 2^(DATA_W-1) and N ≤ 2^LOG2N_MAX; no saturation.
- Twiddle idx=0 must return cos=max positive, sin=0. ROM content is the integrator's responsibility.

Optional Feature:
DFT_INVERSE_EN:
- Defined: adds input i_inverse, latched at start.
- When i_inverse=1:
  - The twiddle sin term is negated (conjugate twiddle), saturating -2^(TW_W-1) to +max.
  - The final bin is arithmetic-shifted right by log2(N) with round half-up before transfer; this applies for power-of-two N only.
  - Non-power-of-two N with i_inverse=1 gives o_err.
- Undefined: port absent, forward transform only.

Decomposition:
- Package dft_pkg holds:
  - the fsm state enum;
  - the complex-sample struct {re, im} parametrised by width via localparam defaults;
  - the rounding constant function;
  - the legal-length check function.
- One natural sub-module: dft_cmul_round, the stage-1 complex multiply plus rounding register.

Test Plan:
- N=4, x=[(1000,0),0,0,0] -> 4 results, each k: re=1000, im=0; o_done 1 cycle after last accept.
- N=4, x all (100,0) -> X0=(400,0), X1..X3=(0,0) ±1 LSB.
- N=4, x=[0,(1000,0),0,(-1000,0)] -> X1=(0,-2000), X3=(0,2000), X0=X2=0 ±1 LSB.
- i_res_ready low for 20 cycles during N=8 run:
  - o_res_valid and o_res_k=0 held stable;
  - the engine stalls in WAIT_OUT;
  - all 8 bins arrive in order after release.
- Reset asserted mid-RUN at k=2 -> all outputs 0 immediately; the next start with N=4 gives correct results.
- i_points=1 and i_points=2^LOG2N_MAX+1 -> o_err pulse, o_busy stays 0, no sample reads.

Source files
------------

// File: rtl/dft_pkg.sv
// rtl/dft_pkg.sv - shared state encoding, sample type and length helpers for the direct-DFT engine
package dft_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN,
      ST_WAIT_OUT,
      ST_FIN
   } dft_state_t;

   localparam int CPLX_W = 16;

   typedef struct packed {
      logic signed [CPLX_W-1:0] re;
      logic signed [CPLX_W-1:0] im;
   } cplx_t;

   // Half an LSB of the Q1.(tw_w-1) product, for round half-up before the shift.
   function automatic int round_const(input int tw_w);
      return 1 << (tw_w - 2);
   endfunction

   function automatic logic legal_points(input logic [31:0] pts, input int log2n_max);
      return (pts >= 32'd2) && (pts <= (32'd1 << log2n_max));
   endfunction

endpackage

// File: rtl/dft_cmul_round.sv
// rtl/dft_cmul_round.sv - sample x twiddle complex multiply, round half-up, registered
module dft_cmul_round
   import dft_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int TW_W   = 16
) (
   input  logic                     clk,
   input  logic                     n_Reset,
   input  logic                     in_valid,
   input  logic                     in_first,
   input  logic signed [DATA_W-1:0] smp_re,
   input  logic signed [DATA_W-1:0] smp_im,
   input  logic signed [TW_W-1:0]   tw_cos,
   input  logic signed [TW_W-1:0]   tw_sin,
   output logic                     out_valid,
   output logic                     out_first,
   output logic signed [DATA_W+1:0] out_re,
   output logic signed [DATA_W+1:0] out_im
);

   localparam int FULL_W = DATA_W + TW_W + 1;
   localparam int SHIFT  = TW_W - 1;
   localparam int OUT_W  = DATA_W + 2;

   logic signed [FULL_W-1:0] a_re, a_im, c, s, prod_re, prod_im;

   always_comb begin
      a_re    = FULL_W'(smp_re);
      a_im    = FULL_W'(smp_im);
      c       = FULL_W'(tw_cos);
      s       = FULL_W'(tw_sin);
      prod_re = a_re * c - a_im * s + FULL_W'(round_const(TW_W));
      prod_im = a_re * s + a_im * c + FULL_W'(round_const(TW_W));
   end

   always_ff @(posedge clk or negedge n_Reset) begin
      if (!n_Reset) begin
         out_valid <= 1'b0;
         out_first <= 1'b0;
         out_re    <= '0;
         out_im    <= '0;
      end else begin
         out_valid <= in_valid;
         out_first <= in_first;
         out_re    <= OUT_W'(prod_re >>> SHIFT);
         out_im    <= OUT_W'(prod_im >>> SHIFT);
      end
   end

endmodule

// File: rtl/dft_mac_engine.sv
// rtl/dft_mac_engine.sv - direct-DFT bin-by-bin MAC engine; define DFT_INVERSE_EN for the inverse transform
module dft_mac_engine
   import dft_pkg::*;
#(
   parameter int DATA_W    = 16,
   parameter int TW_W      = 16,
   parameter int LOG2N_MAX = 12,
   parameter int ACC_W     = DATA_W + LOG2N_MAX + 1
) (
   input  logic                        clk,
   input  logic                        n_Reset,
   input  logic                        i_start,
   input  logic [LOG2N_MAX:0]          i_points,
`ifdef DFT_INVERSE_EN
   input  logic                        i_inverse,
`endif
   output logic                        o_busy,
   output logic                        o_done,
   output logic                        o_err,
   output logic                        o_smp_rd,
   output logic [LOG2N_MAX-1:0]        o_smp_addr,
   input  logic signed [DATA_W-1:0]    i_smp_re,
   input  logic signed [DATA_W-1:0]    i_smp_im,
   output logic [LOG2N_MAX-1:0]        o_tw_addr,
   input  logic signed [TW_W-1:0]      i_tw_cos,
   input  logic signed [TW_W-1:0]      i_tw_sin,
   output logic                        o_res_valid,
   input  logic                        i_res_ready,
   output logic [LOG2N_MAX-1:0]        o_res_k,
   output logic signed [ACC_W-1:0]     o_res_re,
   output logic signed [ACC_W-1:0]     o_res_im
);

   localparam int CNT_W  = LOG2N_MAX;
   localparam int PTS_W  = LOG2N_MAX + 1;
   localparam int PROD_W = DATA_W + 2;

   dft_state_t state_q, state_d;

   logic [PTS_W-1:0]         pts_q;
   logic [CNT_W-1:0]         nm1_q, n_q, k_q, idx_q, idx_next;
   logic [PTS_W-1:0]         idx_sum;
   logic                     issue, xfer, start_ok, start_bad, bin_last, out_free, pipe_empty;
   logic                     points_ok, err_q;
   logic                     v0_q, f0_q, p_valid, p_first;
   logic signed [PROD_W-1:0] p_re, p_im;
   logic signed [ACC_W-1:0]  p_ext_re, p_ext_im, acc_re_q, acc_im_q, res_re, res_im;
   logic signed [TW_W-1:0]   tw_sin_eff;
   logic                     out_valid_q;
   logic [CNT_W-1:0]         out_k_q;
   logic signed [ACC_W-1:0]  out_re_q, out_im_q;

`ifdef DFT_INVERSE_EN
   localparam int L2_W  = $clog2(PTS_W);
   localparam int EXT_W = ACC_W + 1;

   logic                    inv_q;
   logic [L2_W-1:0]         l2n_q, l2n_in;
   logic signed [EXT_W-1:0] half, ext_re, ext_im;

   // Inverse: conjugate twiddle (saturating the most negative sin) and a rounded 1/N scale.
   always_comb begin
      l2n_in = '0;
      for (int i = 0; i < PTS_W; i++) begin
         if (i_points[i]) l2n_in = L2_W'(i);
      end
      points_ok = legal_points(32'(i_points), LOG2N_MAX) &&
                  !(i_inverse && ((i_points & (i_points - PTS_W'(1))) != '0));
      tw_sin_eff = i_tw_sin;
      if (inv_q) begin
         tw_sin_eff = (i_tw_sin == {1'b1, {(TW_W-1){1'b0}}}) ? {1'b0, {(TW_W-1){1'b1}}} : -i_tw_sin;
      end
      half   = EXT_W'(1) <<< (l2n_q - L2_W'(1));
      ext_re = {acc_re_q[ACC_W-1], acc_re_q};
      ext_im = {acc_im_q[ACC_W-1], acc_im_q};
      res_re = inv_q ? ACC_W'((ext_re + half) >>> l2n_q) : acc_re_q;
      res_im = inv_q ? ACC_W'((ext_im + half) >>> l2n_q) : acc_im_q;
   end

   always_ff @(posedge clk or negedge n_Reset) begin
      if (!n_Reset) begin
         inv_q <= 1'b0;
         l2n_q <= '0;
      end else if (start_ok) begin
         inv_q <= i_inverse;
         l2n_q <= l2n_in;
      end
   end
`else
   assign points_ok  = legal_points(32'(i_points), LOG2N_MAX);
   assign tw_sin_eff = i_tw_sin;
   assign res_re     = acc_re_q;
   assign res_im     = acc_im_q;
`endif

   // idx tracks (k*n) mod N incrementally; idx < N and k < N so one subtract suffices.
   assign idx_sum  = {1'b0, idx_q} + {1'b0, k_q};
   assign idx_next = (idx_sum >= pts_q) ? CNT_W'(idx_sum - pts_q) : CNT_W'(idx_sum);

   always_comb begin
      state_d    = state_q;
      issue      = 1'b0;
      xfer       = 1'b0;
      start_ok   = 1'b0;
      start_bad  = 1'b0;
      bin_last   = (k_q == nm1_q);
      out_free   = !out_valid_q || i_res_ready;
      pipe_empty = !v0_q && !p_valid;
      case (state_q)
         ST_IDLE: begin
            if (i_start) begin
               if (points_ok) begin
                  start_ok = 1'b1;
                  state_d  = ST_RUN;
               end else begin
                  start_bad = 1'b1;
               end
            end
         end
         ST_RUN: begin
            issue = 1'b1;
            if (n_q == nm1_q) state_d = ST_DRAIN;
         end
         ST_DRAIN, ST_WAIT_OUT: begin
            if (pipe_empty) begin
               if (out_free) begin
                  xfer    = 1'b1;
                  state_d = bin_last ? ST_FIN : ST_RUN;
               end else begin
                  state_d = ST_WAIT_OUT;
               end
            end
         end
         ST_FIN: begin
            if (!out_valid_q) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   dft_cmul_round #(
      .DATA_W (DATA_W),
      .TW_W   (TW_W)
   ) u_cmul (
      .clk       (clk),
      .n_Reset   (n_Reset),
      .in_valid  (v0_q),
      .in_first  (f0_q),
      .smp_re    (i_smp_re),
      .smp_im    (i_smp_im),
      .tw_cos    (i_tw_cos),
      .tw_sin    (tw_sin_eff),
      .out_valid (p_valid),
      .out_first (p_first),
      .out_re    (p_re),
      .out_im    (p_im)
   );

   assign p_ext_re = {{(ACC_W-PROD_W){p_re[PROD_W-1]}}, p_re};
   assign p_ext_im = {{(ACC_W-PROD_W){p_im[PROD_W-1]}}, p_im};

   always_ff @(posedge clk or negedge n_Reset) begin
      if (!n_Reset) begin
         state_q     <= ST_IDLE;
         err_q       <= 1'b0;
         pts_q       <= '0;
         nm1_q       <= '0;
         n_q         <= '0;
         k_q         <= '0;
         idx_q       <= '0;
         v0_q        <= 1'b0;
         f0_q        <= 1'b0;
         acc_re_q    <= '0;
         acc_im_q    <= '0;
         out_valid_q <= 1'b0;
         out_k_q     <= '0;
         out_re_q    <= '0;
         out_im_q    <= '0;
      end else begin
         state_q <= state_d;
         err_q   <= start_bad;
         v0_q    <= issue;
         f0_q    <= issue && (n_q == '0);
         if (start_ok) begin
            pts_q <= i_points;
            nm1_q <= CNT_W'(i_points - PTS_W'(1));
            n_q   <= '0;
            k_q   <= '0;
            idx_q <= '0;
         end else if (issue) begin
            n_q   <= n_q + CNT_W'(1);
            idx_q <= idx_next;
         end else if (xfer && !bin_last) begin
            k_q   <= k_q + CNT_W'(1);
            n_q   <= '0;
            idx_q <= '0;
         end
         // First product of a bin loads, so the previous bin needs no explicit clear.
         if (p_valid) begin
            acc_re_q <= p_first ? p_ext_re : acc_re_q + p_ext_re;
            acc_im_q <= p_first ? p_ext_im : acc_im_q + p_ext_im;
         end
         if (xfer) begin
            out_valid_q <= 1'b1;
            out_k_q     <= k_q;
            out_re_q    <= res_re;
            out_im_q    <= res_im;
         end else if (i_res_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign o_busy      = (state_q != ST_IDLE);
   assign o_done      = (state_q == ST_FIN) && !out_valid_q;
   assign o_err       = err_q;
   assign o_smp_rd    = issue;
   assign o_smp_addr  = n_q;
   assign o_tw_addr   = idx_q;
   assign o_res_valid = out_valid_q;
   assign o_res_k     = out_k_q;
   assign o_res_re    = out_re_q;
   assign o_res_im    = out_im_q;

endmodule

// File: tb/tb_dft_mac_engine.sv
// tb/tb_dft_mac_engine.sv - directed table-driven bench for dft_mac_engine
module tb_dft_mac_engine;
   import dft_pkg::*;

   localparam int  DATA_W    = 16;
   localparam int  TW_W      = 16;
   localparam int  LOG2N_MAX = 12;
   localparam int  ACC_W     = DATA_W + LOG2N_MAX + 1;
   localparam int  PW        = LOG2N_MAX + 1;
   localparam real PI        = 3.14159265358979;

   logic                     clk = 1'b0;
   logic                     n_Reset = 1'b0;
   logic                     i_start = 1'b0;
   logic [PW-1:0]            i_points = '0;
   logic                     o_busy, o_done, o_err, o_smp_rd, o_res_valid;
   logic [LOG2N_MAX-1:0]     o_smp_addr, o_tw_addr, o_res_k;
   logic signed [DATA_W-1:0] i_smp_re = '0, i_smp_im = '0;
   logic signed [TW_W-1:0]   i_tw_cos = '0, i_tw_sin = '0;
   logic                     i_res_ready = 1'b0;
   logic signed [ACC_W-1:0]  o_res_re, o_res_im;

   dft_mac_engine #(
      .DATA_W(DATA_W), .TW_W(TW_W), .LOG2N_MAX(LOG2N_MAX), .ACC_W(ACC_W)
   ) dut (
      .clk(clk), .n_Reset(n_Reset), .i_start(i_start), .i_points(i_points),
`ifdef DFT_INVERSE_EN
      .i_inverse(1'b0),
`endif
      .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_smp_rd(o_smp_rd),
      .o_smp_addr(o_smp_addr), .i_smp_re(i_smp_re), .i_smp_im(i_smp_im),
      .o_tw_addr(o_tw_addr), .i_tw_cos(i_tw_cos), .i_tw_sin(i_tw_sin),
      .o_res_valid(o_res_valid), .i_res_ready(i_res_ready), .o_res_k(o_res_k),
      .o_res_re(o_res_re), .o_res_im(o_res_im)
   );

   always #5 clk = ~clk;

   cplx_t smp_mem [0:15];
   int    cur_n = 4;

   function automatic int q15(input real v);
      return int'($floor(v * 32767.0 + 0.5));
   endfunction

   // Sample RAM and twiddle ROM, both one-cycle read latency.
   always @(posedge clk) begin
      if (o_smp_rd) begin
         i_smp_re <= smp_mem[o_smp_addr[3:0]].re;
         i_smp_im <= smp_mem[o_smp_addr[3:0]].im;
         i_tw_cos <= 16'(q15($cos(2.0 * PI * real'(o_tw_addr) / real'(cur_n))));
         i_tw_sin <= 16'(q15(-$sin(2.0 * PI * real'(o_tw_addr) / real'(cur_n))));
      end
   end

   typedef struct {
      int case_id;
      int k;
      int re;
      int im;
   } bin_vec_t;

   bin_vec_t tbl [$];
   int got_k [$];
   int got_re [$];
   int got_im [$];
   int n_pass = 0;
   int n_chk  = 0;

   task automatic chk(input string name, input longint act, input longint exp, input longint tol);
      n_chk++;
      if (act >= exp - tol && act <= exp + tol) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic load_case(input int id);
      for (int i = 0; i < 16; i++) smp_mem[i] = '0;
      case (id)
         1: begin cur_n = 4; smp_mem[0].re = 16'(1000); end
         2: begin cur_n = 4; for (int i = 0; i < 4; i++) smp_mem[i].re = 16'(100); end
         3: begin cur_n = 4; smp_mem[1].re = 16'(1000); smp_mem[3].re = 16'(-1000); end
         default: begin cur_n = 8; smp_mem[1].re = 16'(1000); end
      endcase
   endtask

   task automatic start_run(input bit ready);
      got_k.delete(); got_re.delete(); got_im.delete();
      @(negedge clk);
      i_points    = PW'(cur_n);
      i_start     = 1'b1;
      i_res_ready = ready;
      @(negedge clk);
      i_start = 1'b0;
   endtask

   task automatic collect(input int want);
      int budget = 0;
      while (got_k.size() < want && budget < 2000) begin
         if (o_res_valid && i_res_ready) begin
            got_k.push_back(int'(o_res_k));
            got_re.push_back(int'(o_res_re));
            got_im.push_back(int'(o_res_im));
         end
         if (got_k.size() < want) @(negedge clk);
         budget++;
      end
      chk("bins received", got_k.size(), want, 0);
   endtask

   task automatic run_case(input int id, input bit stall);
      int budget = 0;
      int k0_re;
      bit held = 1'b1;
      int idx = 0;
      load_case(id);
      start_run(!stall);
      chk($sformatf("c%0d busy after start", id), o_busy, 1, 0);
      if (stall) begin
         while (!o_res_valid && budget < 200) begin @(negedge clk); budget++; end
         chk("stall first valid", o_res_valid, 1, 0);
         k0_re = int'(o_res_re);
         for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (!o_res_valid || o_res_k != '0 || int'(o_res_re) != k0_re) held = 1'b0;
         end
         chk("stall output held", held, 1, 0);
         chk("stall no reads in wait", o_smp_rd, 0, 0);
         chk("stall busy", o_busy, 1, 0);
         i_res_ready = 1'b1;
      end
      collect(cur_n);
      @(negedge clk);
      chk($sformatf("c%0d done after last accept", id), o_done, 1, 0);
      @(negedge clk);
      chk($sformatf("c%0d done one cycle", id), o_done, 0, 0);
      chk($sformatf("c%0d idle after done", id), o_busy, 0, 0);
      foreach (tbl[t]) begin
         if (tbl[t].case_id == id && idx < got_k.size()) begin
            chk($sformatf("c%0d order %0d", id, idx), got_k[idx], tbl[t].k, 0);
            chk($sformatf("c%0d k%0d re", id, tbl[t].k), got_re[idx], tbl[t].re, 1);
            chk($sformatf("c%0d k%0d im", id, tbl[t].k), got_im[idx], tbl[t].im, 1);
            idx++;
         end
      end
   endtask

   task automatic err_case(input int pts);
      bit rd_seen = 1'b0;
      bit busy_seen = 1'b0;
      bit err_again = 1'b0;
      @(negedge clk);
      i_points = PW'(pts);
      i_start  = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      chk($sformatf("err pulse pts=%0d", pts), o_err, 1, 0);
      for (int c = 0; c < 6; c++) begin
         rd_seen   |= o_smp_rd;
         busy_seen |= o_busy;
         @(negedge clk);
         err_again |= o_err;
      end
      chk($sformatf("err no reads pts=%0d", pts), rd_seen, 0, 0);
      chk($sformatf("err busy low pts=%0d", pts), busy_seen, 0, 0);
      chk($sformatf("err single pulse pts=%0d", pts), err_again, 0, 0);
   endtask

   task automatic reset_check(input string tag);
      chk({tag, " busy"}, o_busy, 0, 0);
      chk({tag, " done/err/rd"}, {o_done, o_err, o_smp_rd}, 0, 0);
      chk({tag, " res_valid"}, o_res_valid, 0, 0);
      chk({tag, " res data"}, (o_res_re != '0) || (o_res_im != '0) || (o_res_k != '0), 0, 0);
      chk({tag, " addrs"}, (o_smp_addr != '0) || (o_tw_addr != '0), 0, 0);
   endtask

   initial begin
      int budget;
      bit leak;

      tbl.push_back('{1, 0, 1000, 0});   tbl.push_back('{1, 1, 1000, 0});
      tbl.push_back('{1, 2, 1000, 0});   tbl.push_back('{1, 3, 1000, 0});
      tbl.push_back('{2, 0, 400, 0});    tbl.push_back('{2, 1, 0, 0});
      tbl.push_back('{2, 2, 0, 0});      tbl.push_back('{2, 3, 0, 0});
      tbl.push_back('{3, 0, 0, 0});      tbl.push_back('{3, 1, 0, -2000});
      tbl.push_back('{3, 2, 0, 0});      tbl.push_back('{3, 3, 0, 2000});
      tbl.push_back('{4, 0, 1000, 0});   tbl.push_back('{4, 1, 707, -707});
      tbl.push_back('{4, 2, 0, -1000});  tbl.push_back('{4, 3, -707, -707});
      tbl.push_back('{4, 4, -1000, 0});  tbl.push_back('{4, 5, -707, 707});
      tbl.push_back('{4, 6, 0, 1000});   tbl.push_back('{4, 7, 707, 707});

      repeat (3) @(negedge clk);
      reset_check("reset");
      n_Reset = 1'b1;
      @(negedge clk);

      run_case(1, 1'b0);
      run_case(2, 1'b0);
      run_case(3, 1'b0);
      run_case(4, 1'b1);

      // Reset while bin 2 is being computed.
      load_case(1);
      start_run(1'b1);
      collect(2);
      @(negedge clk);
      budget = 0;
      while (!o_smp_rd && budget < 50) begin @(negedge clk); budget++; end
      chk("midrun in RUN", o_smp_rd, 1, 0);
      n_Reset = 1'b0;
      #1;
      reset_check("midrun reset");
      repeat (2) @(negedge clk);
      n_Reset = 1'b1;
      leak = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         leak |= o_res_valid | o_busy;
      end
      chk("no result after reset", leak, 0, 0);
      run_case(3, 1'b0);

      err_case(1);
      err_case((1 << LOG2N_MAX) + 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

endmodule
